// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch PC owner, in-order imem requester and decode instruction buffer
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_8000,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]   fetch_pc;
  logic [CW-1:0] live_cnt, drop_cnt, fifo_cnt;
  logic [31:0]   pcq [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc [DEPTH];
  logic [AW-1:0] pcq_wr, pcq_rd, fifo_wr, fifo_rd;
  logic [CW+1:0] used;
  logic          accept, resp_live, resp_drop, pop;
  always_comb begin
    used = (CW+2)'(live_cnt) + (CW+2)'(drop_cnt) + (CW+2)'(fifo_cnt);
    imem_req_valid = !rst && !redirect_valid && (used < (CW+2)'(DEPTH));
    accept = imem_req_valid && imem_req_ready;
    resp_drop = imem_resp_valid && (drop_cnt != '0);
    resp_live = imem_resp_valid && (drop_cnt == '0) && (live_cnt != '0);
    inst_valid = fifo_cnt != '0;
    pop = inst_valid && inst_ready;
    inst_data = inst_valid ? fifo_data[fifo_rd] : '0;
    inst_pc = inst_valid ? fifo_pc[fifo_rd] : '0;
  end
  assign imem_req_addr = fetch_pc;
  assign inst_pc_plus4 = inst_pc + 32'd4;
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      live_cnt <= '0;
      drop_cnt <= '0;
      fifo_cnt <= '0;
      pcq_wr   <= '0;
      pcq_rd   <= '0;
      fifo_wr  <= '0;
      fifo_rd  <= '0;
    end else if (redirect_valid) begin
      // everything still in flight belongs to the squashed stream
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      drop_cnt <= live_cnt + drop_cnt - CW'(resp_live || resp_drop);
      live_cnt <= '0;
      fifo_cnt <= '0;
      pcq_wr   <= '0;
      pcq_rd   <= '0;
      fifo_wr  <= '0;
      fifo_rd  <= '0;
    end else begin
      fetch_pc <= accept ? fetch_pc + 32'd4 : fetch_pc;
      live_cnt <= live_cnt + CW'(accept) - CW'(resp_live);
      drop_cnt <= drop_cnt - CW'(resp_drop);
      fifo_cnt <= fifo_cnt + CW'(resp_live) - CW'(pop);
      pcq_wr   <= pcq_wr + AW'(accept);
      pcq_rd   <= pcq_rd + AW'(resp_live);
      fifo_wr  <= fifo_wr + AW'(resp_live);
      fifo_rd  <= fifo_rd + AW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (accept) pcq[pcq_wr] <= fetch_pc;
    if (resp_live && !rst && !redirect_valid) begin
      fifo_data[fifo_wr] <= imem_resp_data;
      fifo_pc[fifo_wr]   <= pcq[pcq_rd];
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: randomized scoreboard bench with an in-order imem model
module tb_inst_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_8000;
  logic        clk = 0, rst = 1, redirect_valid = 0, imem_req_ready = 0;
  logic        imem_resp_valid = 0, inst_ready = 0;
  logic [31:0] redirect_pc = 0, imem_resp_data = 0;
  logic        imem_req_valid, inst_valid;
  logic [31:0] imem_req_addr, inst_data, inst_pc, inst_pc_plus4;
  int          n_chk = 0, n_fail = 0, acc_cnt = 0, pops = 0;
  int          lat_min = 0, lat_max = 0;
  bit          rdy_rand = 0;
  logic [31:0] mpc = RPC;
  typedef struct {int due; logic [31:0] a;} mreq_t;
  typedef struct {logic [31:0] d; logic [31:0] pc;} exp_t;
  mreq_t mq[$];
  exp_t  exq[$];

  inst_fetch_unit #(.RESET_PC(RPC), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_pc_plus4(inst_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // in-order memory, latency lat_min+1..lat_max+1 cycles, no backpressure on responses
  initial begin
    int cnt, last, due;
    logic acc, rs;
    logic [31:0] a;
    cnt = 0;
    last = 0;
    forever begin
      @(posedge clk);
      acc = imem_req_valid && imem_req_ready;
      a = imem_req_addr;
      rs = rst;
      #1;
      cnt++;
      if (rs) begin
        mq.delete();
        last = 0;
      end else if (acc) begin
        due = cnt + $urandom_range(lat_min, lat_max);
        if (due <= last) due = last + 1;
        last = due;
        mq.push_back('{due, a});
      end
      if (mq.size() > 0 && mq[0].due <= cnt) begin
        imem_resp_valid = 1;
        imem_resp_data = memf(mq[0].a);
        void'(mq.pop_front());
      end else begin
        imem_resp_valid = 0;
        imem_resp_data = 0;
      end
      imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // reference stream: consecutive word PCs from the last restart point
  initial forever begin
    @(posedge clk);
    if (rst) begin
      exq.delete();
      mpc = RPC;
    end else if (redirect_valid) begin
      chk("no_req_on_redirect", 32'(imem_req_valid), 0);
      exq.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, mpc);
      exq.push_back('{memf(mpc), mpc});
      mpc = mpc + 32'd4;
      acc_cnt++;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && inst_ready) begin
        pops++;
        if (exq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_inst: got pc %h, expected no instruction", inst_pc);
        end else begin
          e = exq.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst_data", inst_data, e.d);
          chk("inst_pc_plus4", inst_pc_plus4, e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    int a0, v;
    bit seen;
    inst_ready = 1;
    cyc(3);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, 0);
    cyc(1);
    rst = 0;
    @(negedge clk);
    chk("first_req_valid", 32'(imem_req_valid), 1);
    chk("first_req_addr", imem_req_addr, RPC);
    cyc(2);
    v = 0;
    repeat (20) begin
      @(negedge clk);
      v += int'(inst_valid);
    end
    chk("throughput", v, 20);
    cyc(1);
    rst = 1;
    inst_ready = 0;
    cyc(2);
    rst = 0;
    a0 = acc_cnt;
    cyc(10);
    @(negedge clk);
    chk("stall_accepts", acc_cnt - a0, 4);
    chk("stall_req_valid", 32'(imem_req_valid), 0);
    chk("stall_inst_valid", 32'(inst_valid), 1);
    cyc(1);
    inst_ready = 1;
    cyc(1);
    inst_ready = 0;
    a0 = acc_cnt;
    cyc(6);
    @(negedge clk);
    chk("one_pop_one_req", acc_cnt - a0, 1);
    cyc(1);
    inst_ready = 1;
    cyc(8);
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFE;
    cyc(1);
    redirect_valid = 0;
    @(negedge clk);
    chk("redirect_inst_valid", 32'(inst_valid), 0);
    chk("wrap_req_valid", 32'(imem_req_valid), 1);
    chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    cyc(1);
    @(negedge clk);
    chk("wrap_addr1", imem_req_addr, 32'h0000_0000);
    lat_max = 3;
    cyc(8);
    redirect_valid = 1;
    redirect_pc = 32'h0000_0100;
    cyc(1);
    redirect_valid = 0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        seen = 1;
        chk("redir_first_pc", inst_pc, 32'h0000_0100);
        chk("redir_first_data", inst_data, memf(32'h0000_0100));
      end
    end
    chk("redir_first_seen", 32'(seen), 1);
    lat_min = 3;
    lat_max = 3;
    cyc(8);
    redirect_valid = 1;
    redirect_pc = 32'h0000_2000;
    cyc(1);
    redirect_valid = 0;
    @(negedge clk);
    chk("drain_entered", 32'(dut.drop_cnt != 0), 1);
    cyc(1);
    rst = 1;
    cyc(1);
    rst = 0;
    @(negedge clk);
    chk("drain_rst_inst_valid", 32'(inst_valid), 0);
    chk("drain_rst_drop_cnt", 32'(dut.drop_cnt), 0);
    chk("drain_rst_req_valid", 32'(imem_req_valid), 1);
    chk("drain_rst_addr", imem_req_addr, RPC);
    lat_min = 0;
    lat_max = 3;
    rdy_rand = 1;
    repeat (3000) begin
      cyc(1);
      inst_ready = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 39) == 0;
      redirect_pc = $urandom_range(0, 1) != 0 ? $urandom : 32'hFFFF_FFF0 + $urandom_range(0, 15);
      rst = $urandom_range(0, 399) == 0;
    end
    cyc(1);
    rst = 0;
    redirect_valid = 0;
    inst_ready = 1;
    cyc(30);
    chk("pops_seen", 32'(pops > 300), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
